// File: rtl/seq_controller.sv
// seq_controller: FETCH/WAIT/EXEC/WB instruction sequencer with HALT.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes 1001/1110 into HALT.
module seq_controller #(
    parameter int INSTR_W     = 8,
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 4,
    parameter int WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               Zero,
    input  logic               Carry,
    input  logic               resume,
    output logic               LoadIR,
    output logic               IncPC,
    output logic               SelPC,
    output logic               LoadPC,
    output logic               LoadReg,
    output logic               DumpReg,
    output logic               LoadAcc,
    output logic               DumpAcc,
    output logic               SelAcc0,
    output logic               SelAcc1,
    output logic [3:0]         SelALU,
    output logic [DATA_W-1:0]  ImmediateData,
    output logic [REG_AW-1:0]  RegNumber,
    output logic               alu_enable,
    output logic               halted,
    output logic               illegal
);

    localparam int OP_W  = INSTR_W - 4;
    localparam int EXT_W = (DATA_W > OP_W) ? DATA_W : OP_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0100;
    localparam logic [3:0] OP_STR = 4'b0101;
    localparam logic [3:0] OP_JZR = 4'b0110;
    localparam logic [3:0] OP_JZI = 4'b0111;
    localparam logic [3:0] OP_JCR = 4'b1000;
    localparam logic [3:0] OP_JCI = 4'b1010;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_LDI = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_FPEND,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              halt_pend;

    logic [3:0]        opcode;
    logic [OP_W-1:0]   operand;
    logic [EXT_W-1:0]  op_ext;
    logic              go_exec;

    logic              d_dump_reg;
    logic              d_load_reg;
    logic              d_load_acc;
    logic              d_dump_acc;
    logic              d_acc0;
    logic              d_acc1;
    logic              d_alu;
    logic              d_load_pc;
    logic              d_sel_pc;
    logic              d_halt;
    logic              d_trap;
    logic [3:0]        d_alu_op;

    assign opcode  = Instr[INSTR_W-1 -: 4];
    assign operand = Instr[OP_W-1:0];
    assign op_ext  = EXT_W'(operand);

    assign go_exec = (state == S_FETCH && WAIT_CYCLES == 0) ||
                     (state == S_WAIT && wait_cnt == 4'd1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign d_trap = (opcode == 4'b1001) || (opcode == 4'b1110);
`else
    assign d_trap = 1'b0;
`endif

    always_comb begin
        d_dump_reg = 1'b0;
        d_load_reg = 1'b0;
        d_load_acc = 1'b0;
        d_dump_acc = 1'b0;
        d_acc0     = 1'b0;
        d_acc1     = 1'b0;
        d_alu      = 1'b0;
        d_load_pc  = 1'b0;
        d_sel_pc   = 1'b0;
        d_halt     = 1'b0;
        d_alu_op   = 4'b0000;
        unique case (1'b1)
            (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_NOR): begin
                d_dump_reg = 1'b1;
                d_load_acc = 1'b1;
                d_acc1     = 1'b1;
                d_alu      = 1'b1;
                d_alu_op   = opcode;
            end
            (opcode == OP_SHR || opcode == OP_SHL): begin
                d_load_acc = 1'b1;
                d_acc1     = 1'b1;
                d_alu      = 1'b1;
                d_alu_op   = (opcode == OP_SHR) ? 4'b1100 : 4'b1101;
            end
            (opcode == OP_LDR): begin
                d_dump_reg = 1'b1;
                d_load_acc = 1'b1;
                d_acc0     = 1'b1;
            end
            (opcode == OP_STR): begin
                d_load_reg = 1'b1;
                d_dump_acc = 1'b1;
            end
            (opcode == OP_LDI): d_load_acc = 1'b1;
            (opcode == OP_JZR): d_load_pc = Zero;
            (opcode == OP_JZI): begin
                d_load_pc = Zero;
                d_sel_pc  = Zero;
            end
            (opcode == OP_JCR): d_load_pc = Carry;
            (opcode == OP_JCI): begin
                d_load_pc = Carry;
                d_sel_pc  = Carry;
            end
            (opcode == OP_HLT): d_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_FPEND;
            wait_cnt      <= WAIT_INIT;
            halt_pend     <= 1'b0;
            LoadIR        <= 1'b0;
            IncPC         <= 1'b0;
            SelPC         <= 1'b0;
            LoadPC        <= 1'b0;
            LoadReg       <= 1'b0;
            DumpReg       <= 1'b0;
            LoadAcc       <= 1'b0;
            DumpAcc       <= 1'b0;
            SelAcc0       <= 1'b0;
            SelAcc1       <= 1'b0;
            SelALU        <= '0;
            ImmediateData <= '0;
            RegNumber     <= '0;
            alu_enable    <= 1'b0;
            halted        <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            LoadIR     <= 1'b0;
            IncPC      <= 1'b0;
            SelPC      <= 1'b0;
            LoadPC     <= 1'b0;
            LoadReg    <= 1'b0;
            DumpReg    <= 1'b0;
            LoadAcc    <= 1'b0;
            DumpAcc    <= 1'b0;
            SelAcc0    <= 1'b0;
            SelAcc1    <= 1'b0;
            SelALU     <= '0;
            alu_enable <= 1'b0;
            halted     <= 1'b0;
            unique case (state)
                S_FPEND, S_WB: begin
                    state  <= S_FETCH;
                    LoadIR <= 1'b1;
                end
                S_FETCH: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= (WAIT_CYCLES == 0) ? S_EXEC : S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= S_EXEC;
                end
                S_EXEC: begin
                    if (halt_pend) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_WB;
                        // a taken jump already loaded the PC in EXEC
                        IncPC <= ~LoadPC;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state <= S_WB;
                        IncPC <= 1'b1;
                    end else begin
                        halted <= 1'b1;
                    end
                end
                default: state <= S_FPEND;
            endcase
            if (go_exec) begin
                DumpReg       <= d_dump_reg;
                LoadReg       <= d_load_reg;
                LoadAcc       <= d_load_acc;
                DumpAcc       <= d_dump_acc;
                SelAcc0       <= d_acc0;
                SelAcc1       <= d_acc1;
                alu_enable    <= d_alu;
                SelALU        <= d_alu_op;
                LoadPC        <= d_load_pc;
                SelPC         <= d_sel_pc;
                RegNumber     <= operand[REG_AW-1:0];
                ImmediateData <= op_ext[DATA_W-1:0];
                halt_pend     <= d_halt | d_trap;
                illegal       <= illegal | d_trap;
            end
        end
    end

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: vector table, directed corner sequences and random
// instructions checked cycle by cycle against a behavioural model.
module tb_seq_controller;

    localparam int W0 = 4;

    localparam logic [15:0] LIR  = 16'h8000;
    localparam logic [15:0] INC  = 16'h4000;
    localparam logic [15:0] SPC  = 16'h2000;
    localparam logic [15:0] LPC  = 16'h1000;
    localparam logic [15:0] LREG = 16'h0800;
    localparam logic [15:0] DREG = 16'h0400;
    localparam logic [15:0] LACC = 16'h0200;
    localparam logic [15:0] DACC = 16'h0100;
    localparam logic [15:0] A0   = 16'h0080;
    localparam logic [15:0] A1   = 16'h0040;
    localparam logic [15:0] ALU  = 16'h0020;
    localparam logic [15:0] HLT  = 16'h0010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] Instr = 8'h00;
    logic Zero = 1'b0, Carry = 1'b0, resume = 1'b0;
    logic LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg;
    logic LoadAcc, DumpAcc, SelAcc0, SelAcc1, alu_enable, halted, illegal;
    logic [3:0] SelALU;
    logic [7:0] ImmediateData;
    logic [3:0] RegNumber;
    logic [15:0] obs;

    logic [11:0] b_instr = 12'hDAB;
    logic b_zero = 1'b0, b_carry = 1'b0, b_resume = 1'b0;
    logic b_lir, b_inc, b_spc, b_lpc, b_lreg, b_dreg;
    logic b_lacc, b_dacc, b_a0, b_a1, b_alu, b_hlt, b_ill;
    logic [3:0] b_selalu;
    logic [15:0] b_imm;
    logic [3:0] b_reg;
    logic [15:0] b_obs;

    assign obs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc,
                  DumpAcc, SelAcc0, SelAcc1, alu_enable, halted, SelALU};
    assign b_obs = {b_lir, b_inc, b_spc, b_lpc, b_lreg, b_dreg, b_lacc,
                    b_dacc, b_a0, b_a1, b_alu, b_hlt, b_selalu};

    seq_controller u0 (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
        .Carry(Carry), .resume(resume), .LoadIR(LoadIR), .IncPC(IncPC),
        .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg),
        .DumpReg(DumpReg), .LoadAcc(LoadAcc), .DumpAcc(DumpAcc),
        .SelAcc0(SelAcc0), .SelAcc1(SelAcc1), .SelALU(SelALU),
        .ImmediateData(ImmediateData), .RegNumber(RegNumber),
        .alu_enable(alu_enable), .halted(halted), .illegal(illegal)
    );

    seq_controller #(
        .INSTR_W(12), .DATA_W(16), .REG_AW(4), .WAIT_CYCLES(0)
    ) u1 (
        .clk(clk), .reset(reset_b), .Instr(b_instr), .Zero(b_zero),
        .Carry(b_carry), .resume(b_resume), .LoadIR(b_lir), .IncPC(b_inc),
        .SelPC(b_spc), .LoadPC(b_lpc), .LoadReg(b_lreg),
        .DumpReg(b_dreg), .LoadAcc(b_lacc), .DumpAcc(b_dacc),
        .SelAcc0(b_a0), .SelAcc1(b_a1), .SelALU(b_selalu),
        .ImmediateData(b_imm), .RegNumber(b_reg),
        .alu_enable(b_alu), .halted(b_hlt), .illegal(b_ill)
    );

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  ins;
        logic        z;
        logic        c;
        logic [15:0] ex;
        logic        inc;
    } vec_t;

    vec_t vt[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected EXEC-cycle strobes straight from the opcode table.
    function automatic logic [15:0] model_exec(input logic [3:0] op,
                                               input logic z,
                                               input logic c);
        logic taken;
        if (op inside {4'h1, 4'h2, 4'h3})
            return DREG | LACC | A1 | ALU | {12'h000, op};
        if (op == 4'hC) return LACC | A1 | ALU | 16'h000C;
        if (op == 4'hB) return LACC | A1 | ALU | 16'h000D;
        if (op == 4'h4) return DREG | LACC | A0;
        if (op == 4'h5) return LREG | DACC;
        if (op == 4'hD) return LACC;
        if (op inside {4'h6, 4'h7, 4'h8, 4'hA}) begin
            taken = (op inside {4'h6, 4'h7}) ? z : c;
            if (!taken) return 16'h0000;
            return (op inside {4'h7, 4'hA}) ? (LPC | SPC) : LPC;
        end
        return 16'h0000;
    endfunction

    function automatic logic model_inc(input logic [3:0] op,
                                       input logic z, input logic c);
        if (op inside {4'h6, 4'h7}) return !z;
        if (op inside {4'h8, 4'hA}) return !c;
        return 1'b1;
    endfunction

    // Entered on a FETCH cycle, returns on the next FETCH cycle.
    task automatic run_instr(input logic [7:0] ins, input logic z,
                             input logic c, input logic [15:0] ex,
                             input logic inc, input string tag);
        chk({tag, ":fetch"}, obs, LIR);
        Instr = ins;
        Zero = ~z;
        Carry = ~c;
        for (int i = 0; i < W0; i++) begin
            tick();
            chk({tag, ":wait"}, obs, 0);
            resume = (i == 1);
            if (i == W0 - 1) begin
                Zero = z;
                Carry = c;
            end
        end
        resume = 1'b0;
        tick();
        chk({tag, ":exec"}, obs, ex);
        chk({tag, ":regnum"}, RegNumber, ins[3:0]);
        chk({tag, ":imm"}, ImmediateData, {4'h0, ins[3:0]});
        Zero = ~z;
        Carry = ~c;
        tick();
        chk({tag, ":wb"}, obs, inc ? INC : 16'h0000);
        tick();
    endtask

    task automatic run_halt(input logic [7:0] ins, input int hold,
                            input string tag);
        chk({tag, ":fetch"}, obs, LIR);
        Instr = ins;
        repeat (W0) begin
            tick();
            chk({tag, ":wait"}, obs, 0);
        end
        tick();
        chk({tag, ":exec"}, obs, 0);
        tick();
        for (int i = 0; i < hold; i++) begin
            chk({tag, ":hold"}, obs, HLT);
            Zero = 1'($urandom);
            Carry = 1'($urandom);
            resume = (i == hold - 1);
            tick();
        end
        chk({tag, ":resume_wb"}, obs, INC);
        resume = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt.push_back('{8'h13, 1'b0, 1'b0, DREG|LACC|A1|ALU|16'h1, 1'b1});
        vt.push_back('{8'h25, 1'b1, 1'b1, DREG|LACC|A1|ALU|16'h2, 1'b1});
        vt.push_back('{8'h3F, 1'b0, 1'b1, DREG|LACC|A1|ALU|16'h3, 1'b1});
        vt.push_back('{8'hC2, 1'b1, 1'b0, LACC|A1|ALU|16'hC, 1'b1});
        vt.push_back('{8'hB7, 1'b0, 1'b0, LACC|A1|ALU|16'hD, 1'b1});
        vt.push_back('{8'h49, 1'b0, 1'b0, DREG|LACC|A0, 1'b1});
        vt.push_back('{8'h5A, 1'b1, 1'b1, LREG|DACC, 1'b1});
        vt.push_back('{8'hD5, 1'b0, 1'b0, LACC, 1'b1});
        vt.push_back('{8'h7A, 1'b1, 1'b0, LPC|SPC, 1'b0});
        vt.push_back('{8'h7A, 1'b0, 1'b1, 16'h0000, 1'b1});
        vt.push_back('{8'h61, 1'b1, 1'b0, LPC, 1'b0});
        vt.push_back('{8'h8E, 1'b0, 1'b1, LPC, 1'b0});
        vt.push_back('{8'h8E, 1'b1, 1'b0, 16'h0000, 1'b1});
        vt.push_back('{8'hA3, 1'b0, 1'b1, LPC|SPC, 1'b0});
        vt.push_back('{8'h00, 1'b1, 1'b1, 16'h0000, 1'b1});

        #2;
        reset = 1'b0;
        reset_b = 1'b0;
        repeat (2) tick();
        chk("rst:obs", obs, 0);
        chk("rst:imm", ImmediateData, 0);
        chk("rst:reg", RegNumber, 0);
        chk("rst:illegal", illegal, 0);
        chk("rst_b:obs", b_obs, 0);
        chk("rst_b:imm", b_imm, 0);

        reset = 1'b1;
        tick();
        foreach (vt[i])
            run_instr(vt[i].ins, vt[i].z, vt[i].c, vt[i].ex, vt[i].inc,
                      $sformatf("vec%0d", i));

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ins;
            logic z;
            logic c;
            do ins = 8'($urandom_range(0, 255));
            while (ins[7:4] inside {4'h9, 4'hE, 4'hF});
            z = 1'($urandom);
            c = 1'($urandom);
            run_instr(ins, z, c, model_exec(ins[7:4], z, c),
                      model_inc(ins[7:4], z, c), $sformatf("rnd%0d", k));
        end

        run_halt(8'hF0, 20, "halt");

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_halt(8'h90, 3, "trap");
        chk("trap:illegal", illegal, 1);
`else
        run_instr(8'h90, 1'b0, 1'b0, 16'h0000, 1'b1, "ill_nop");
        chk("ill_nop:illegal", illegal, 0);
`endif

        run_instr(8'h5A, 1'b0, 1'b0, LREG | DACC, 1'b1, "pre_rst");
        chk("mid_rst:fetch", obs, LIR);
        Instr = 8'hD5;
        tick();
        tick();
        chk("mid_rst:wait", obs, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst:async_obs", obs, 0);
        chk("mid_rst:async_reg", RegNumber, 0);
        chk("mid_rst:async_ill", illegal, 0);
        Instr = 8'h00;
        repeat (3) begin
            tick();
            chk("mid_rst:hold", obs, 0);
        end
        reset = 1'b1;
        tick();
        run_instr(8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, "post_rst");

        reset_b = 1'b1;
        tick();
        chk("w0:fetch", b_obs, LIR);
        tick();
        chk("w0:exec", b_obs, LACC);
        chk("w0:imm", b_imm, 16'h00AB);
        chk("w0:reg", b_reg, 4'hB);
        tick();
        chk("w0:wb", b_obs, INC);
        tick();
        chk("w0:refetch", b_obs, LIR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
